// File: rtl/regfile_scoreboard_nbit.sv
// Register file with a per-register pending-write scoreboard for in-order issue.
// Register 0 is hardwired to zero and can never become busy.
module regfile_scoreboard_nbit #(
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    write_reg,
  input  logic [N-1:0]         write_data,
  input  logic [ADDR_W-1:0]    read_reg1,
  input  logic [ADDR_W-1:0]    read_reg2,
  output logic [N-1:0]         read_data1,
  output logic [N-1:0]         read_data2,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rs1,
  input  logic [ADDR_W-1:0]    issue_rs2,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic                 flush,
  output logic                 stall,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]      busy_count
);

  localparam int D = 1 << ADDR_W;

  logic [N-1:0]    r_regs [D];
  logic [D-1:0]    r_busy;
  logic [ADDR_W:0] r_busy_count;

  logic [D-1:0]    w_wr_hit;
  logic [D-1:0]    w_hazard;
  logic [D-1:0]    w_busy_next;
  logic [ADDR_W:0] w_count_next;
  logic            w_accept;
  logic            w_stall;

  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < D; i++) begin
      w_wr_hit[i] = write && (write_reg == ADDR_W'(i));
    end
  end

  // A writeback landing this cycle resolves the hazard on its register.
  assign w_hazard = r_busy & ~w_wr_hit;
  assign w_stall  = issue_valid && !flush &&
                    (w_hazard[issue_rs1] || w_hazard[issue_rs2] || w_hazard[issue_rd]);
  assign w_accept = issue_valid && !flush && !w_stall;

  // Set beats clear for the same register; flush overrides both.
  always_comb begin
    w_busy_next = r_busy & ~w_wr_hit;
    if (w_accept && (issue_rd != '0)) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    if (flush) begin
      w_busy_next = '0;
    end
    w_busy_next[0] = 1'b0;
  end

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < D; i++) begin
      w_count_next = w_count_next + {{ADDR_W{1'b0}}, w_busy_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_next;
      r_busy_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        r_regs[i] <= '0;
      end
    end else if (write && (write_reg != '0)) begin
      r_regs[write_reg] <= write_data;
    end
  end

  assign read_data1 = (read_reg1 == '0) ? '0 :
                      ((BYPASS == 1) && write && (write_reg == read_reg1)) ? write_data :
                      r_regs[read_reg1];
  assign read_data2 = (read_reg2 == '0) ? '0 :
                      ((BYPASS == 1) && write && (write_reg == read_reg2)) ? write_data :
                      r_regs[read_reg2];

  assign stall      = w_stall;
  assign busy       = r_busy;
  assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_scoreboard_nbit.sv
// Bench for regfile_scoreboard_nbit: directed scenarios plus randomized traffic
// checked against an array-based model of the register file and scoreboard.
module tb_regfile_scoreboard_nbit;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [AW-1:0] write_reg;
  logic [N-1:0]  write_data;
  logic [AW-1:0] read_reg1, read_reg2;
  logic [N-1:0]  read_data1, read_data2;
  logic          issue_valid;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          flush;
  logic          stall;
  logic [D-1:0]  busy;
  logic [AW:0]   busy_count;

  regfile_scoreboard_nbit #(.N(N), .ADDR_W(AW), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .write(write), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_data1(read_data1), .read_data2(read_data2),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .flush(flush), .stall(stall), .busy(busy), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] m_regs [D];
  bit           m_busy [D];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < D; i++) c += m_busy[i] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [D-1:0] m_busy_vec();
    logic [D-1:0] v = '0;
    for (int i = 0; i < D; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_read(input logic [AW-1:0] r);
    if (r == 0) return '0;
    if (write && write_reg == r) return write_data;
    return m_regs[r];
  endfunction

  function automatic bit m_hazard(input logic [AW-1:0] r);
    return m_busy[r] && !(write && write_reg == r);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    write = 0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    issue_valid = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    flush = 0;
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic step();
    bit exp_stall;
    bit acc;
    #1;
    exp_stall = issue_valid && !flush &&
                (m_hazard(issue_rs1) || m_hazard(issue_rs2) || m_hazard(issue_rd));
    chk("read_data1", read_data1, m_read(read_reg1));
    chk("read_data2", read_data2, m_read(read_reg2));
    chk("stall", stall, exp_stall);
    acc = issue_valid && !flush && !exp_stall;
    @(posedge clk);
    if (write && write_reg != 0) m_regs[write_reg] = write_data;
    if (flush) begin
      for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
    end else begin
      if (write) m_busy[write_reg] = 1'b0;
      if (acc && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    #1;
    chk("busy", busy, m_busy_vec());
    chk("busy_count", busy_count, m_count());
    @(negedge clk);
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd);
    idle();
    issue_valid = 1; issue_rs1 = AW'(rs1); issue_rs2 = AW'(rs2); issue_rd = AW'(rd);
  endtask

  initial begin
    idle();
    m_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, '0);
    chk("reset_count", busy_count, '0);
    rst = 1;
    @(negedge clk);

    // Same-cycle bypass and hardwired zero
    idle();
    write = 1; write_reg = 5; write_data = 32'hDEADBEEF; read_reg1 = 5; read_reg2 = 0;
    #1;
    chk("bypass_rd1", read_data1, 32'hDEADBEEF);
    chk("zero_rd2", read_data2, 32'h0);
    step();

    // Producer on r7, dependent stalls, writeback releases it
    issue(0, 0, 7);
    step();
    issue(7, 0, 0);
    #1;
    chk("dep_stall", stall, 1'b1);
    chk("dep_busy7", busy[7], 1'b1);
    chk("dep_count", busy_count, 1);
    step();
    issue(7, 0, 0);
    write = 1; write_reg = 7; write_data = 32'h77;
    #1;
    chk("wb_nostall", stall, 1'b0);
    step();
    chk("wb_busy7", busy[7], 1'b0);

    // Issue and writeback on r3 in the same cycle: set wins
    issue(0, 0, 3);
    write = 1; write_reg = 3; write_data = 32'h55;
    step();
    chk("setwin_busy3", busy[3], 1'b1);
    idle();
    read_reg1 = 3;
    #1;
    chk("setwin_data3", read_data1, 32'h55);
    write = 1; write_reg = 3; write_data = 32'h55;
    step();

    // Flush with busy on 1, 2, 9 overrides a concurrent issue
    issue(0, 0, 1); step();
    issue(0, 0, 2); step();
    issue(0, 0, 9); step();
    chk("pre_flush_count", busy_count, 3);
    issue(0, 0, 4);
    flush = 1;
    #1;
    chk("flush_nostall", stall, 1'b0);
    step();
    chk("flush_busy", busy, '0);
    chk("flush_count", busy_count, 0);

    // Asynchronous reset between edges
    idle();
    write = 1; write_reg = 10; write_data = 32'h1234;
    issue_valid = 1; issue_rd = 12;
    step();
    idle();
    read_reg1 = 10;
    #1;
    chk("pre_rst_r10", read_data1, 32'h1234);
    #1;
    rst = 0;
    m_reset();
    #1;
    chk("rst_r10", read_data1, 32'h0);
    chk("rst_busy", busy, '0);
    chk("rst_count", busy_count, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // Destination r0 never stalls nor sets busy
    for (int k = 0; k < 4; k++) begin
      issue(0, 0, 0);
      #1;
      chk("rd0_stall", stall, 1'b0);
      step();
      chk("rd0_count", busy_count, 0);
    end

    // Randomized traffic; narrow address range most of the time to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? D - 1 : 7;
      write       = ($urandom_range(0, 9) < 4);
      write_reg   = AW'($urandom_range(0, lim));
      write_data  = $urandom;
      read_reg1   = ($urandom_range(0, 1) == 0) ? write_reg : AW'($urandom_range(0, lim));
      read_reg2   = AW'($urandom_range(0, lim));
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_rs1   = AW'($urandom_range(0, lim));
      issue_rs2   = AW'($urandom_range(0, lim));
      issue_rd    = AW'($urandom_range(0, lim));
      flush       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1;
        rst = 0;
        m_reset();
        #1;
        chk("rnd_rst_busy", busy, '0);
        chk("rnd_rst_count", busy_count, 0);
        @(negedge clk);
        rst = 1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
